// File: rtl/rr_arb4_code_gen.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb4_code_gen
// Description : Four-requester round-robin arbiter producing a 2-bit binary
//               grant code for a downstream 2-to-4 one-hot decoder. A grant
//               is held until the owner releases, the owner drops its
//               request, or the hold counter reaches HOLD_MAX-1.
//
// Ports       : clk           in  1  rising-edge clock
//               rst           in  1  synchronous, active-high reset
//               req           in  4  request vector, bit i = requester i
//               owner_release in  1  current owner finished (ignored in IDLE)
//               grant_code    out 2  index of granted requester
//               grant_valid   out 1  grant_code is valid
//               timeout       out 1  1-cycle pulse when grant revoked by
//                                    hold timeout
//
//               The release input is named owner_release because "release"
//               is a reserved word in SystemVerilog.
//
// Revision    : 1.0  initial release
// ============================================================================
module rr_arb4_code_gen #(
    parameter int HOLD_MAX = 15,   // 1 .. 2**CNT_W
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       owner_release,
    output logic [1:0] grant_code,
    output logic       grant_valid,
    output logic       timeout
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(HOLD_MAX - 1);

    logic [0:0]       r_state;
    logic [1:0]       r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_grant_code;
    logic             r_grant_valid;
    logic             r_timeout;

    logic [0:0]       w_state_nxt;
    logic [1:0]       w_ptr_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       w_code_nxt;
    logic             w_valid_nxt;
    logic             w_tmo_nxt;

    // ------------------------------------------------------------------
    // Round-robin pick: rotate the request vector so that bit 0 is the
    // requester at ptr, take the lowest set bit, then add ptr back.
    // ------------------------------------------------------------------
    logic [7:0] w_dbl;
    logic [7:0] w_rot;
    logic [1:0] w_off;
    logic [1:0] w_idx;
    logic       w_any;

    assign w_dbl = {req, req};
    assign w_rot = w_dbl >> r_ptr;
    assign w_any = |req;
    assign w_idx = r_ptr + w_off;

    always_comb begin
        w_off = 2'd0;
        for (int j = 3; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = 2'(j);
            end
        end
    end

    // Grant-termination conditions, meaningful only in BUSY.
    logic w_end_rel;
    logic w_end_drop;
    logic w_end_tmo;
    logic w_end;

    assign w_end_rel  = owner_release;
    assign w_end_drop = ~req[r_grant_code];
    assign w_end_tmo  = (r_cnt == c_cnt_last);
    assign w_end      = w_end_rel | w_end_drop | w_end_tmo;

    // ------------------------------------------------------------------
    // State register (also registers every output and the datapath)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_ptr         <= 2'd0;
            r_cnt         <= '0;
            r_grant_code  <= 2'b00;
            r_grant_valid <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ptr         <= w_ptr_nxt;
            r_cnt         <= w_cnt_nxt;
            r_grant_code  <= w_code_nxt;
            r_grant_valid <= w_valid_nxt;
            r_timeout     <= w_tmo_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_any) w_state_nxt = S_BUSY;
            S_BUSY: if (w_end) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_code_nxt  = r_grant_code;   // code is retained while not valid
        w_valid_nxt = 1'b0;
        w_tmo_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_code_nxt  = w_idx;
                    w_valid_nxt = 1'b1;
                    w_cnt_nxt   = '0;
                end
            end
            S_BUSY: begin
                if (w_end) begin
                    w_ptr_nxt = r_grant_code + 2'd1;
                    w_cnt_nxt = '0;
                    // Release and request-drop take precedence over timeout.
                    w_tmo_nxt = w_end_tmo & ~w_end_rel & ~w_end_drop;
                end else begin
                    w_valid_nxt = 1'b1;
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    assign grant_code  = r_grant_code;
    assign grant_valid = r_grant_valid;
    assign timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb4_code_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arb4_code_gen
// Description : Self-checking bench for rr_arb4_code_gen (HOLD_MAX=15).
//               Table rows give inputs applied before a clock edge and the
//               outputs expected just after that edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rr_arb4_code_gen;

    localparam int HOLD_MAX = 15;
    localparam int CNT_W    = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       rel;
    logic [1:0] grant_code;
    logic       grant_valid;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    rr_arb4_code_gen #(
        .HOLD_MAX (HOLD_MAX),
        .CNT_W    (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .owner_release (rel),
        .grant_code    (grant_code),
        .grant_valid   (grant_valid),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       rel;
        logic [1:0] code;
        logic       valid;
        logic       tmo;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic [3:0] q, input logic l,
                                input logic [1:0] c, input logic v, input logic t);
        vec_t e;
        e.rst = r; e.req = q; e.rel = l; e.code = c; e.valid = v; e.tmo = t;
        vecs.push_back(e);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [1:0] c, input logic v, input logic t);
        total++;
        if ({grant_code, grant_valid, timeout} !== {c, v, t}) begin
            bad++;
            $display("FAIL %s: got code=%b valid=%b tmo=%b, want code=%b valid=%b tmo=%b",
                     name, grant_code, grant_valid, timeout, c, v, t);
        end
    endtask

    initial begin
        rst = 1'b1; req = 4'b0000; rel = 1'b0;

        // Reset held with all requests pending.
        add(1, 4'b1111, 0, 2'b00, 0, 0);
        add(1, 4'b1111, 0, 2'b00, 0, 0);
        // Single requester 2, then release; next search starts at 3.
        add(0, 4'b0100, 0, 2'b10, 1, 0);
        add(0, 4'b0100, 1, 2'b10, 0, 0);
        add(0, 4'b1110, 0, 2'b11, 1, 0);
        add(0, 4'b1110, 1, 2'b11, 0, 0);
        // Release while idle is ignored.
        add(0, 4'b0000, 1, 2'b11, 0, 0);
        // Full rotation from reset, release on 3rd valid cycle.
        add(1, 4'b0000, 0, 2'b00, 0, 0);
        for (int g = 0; g < 5; g++) begin
            add(0, 4'b1111, 0, 2'(g), 1, 0);
            add(0, 4'b1111, 0, 2'(g), 1, 0);
            add(0, 4'b1111, 0, 2'(g), 1, 0);
            add(0, 4'b1111, 1, 2'(g), 0, 0);
        end
        // Owner drops request: no timeout pulse.
        add(1, 4'b0000, 0, 2'b00, 0, 0);
        add(0, 4'b0010, 0, 2'b01, 1, 0);
        add(0, 4'b0000, 0, 2'b01, 0, 0);
        // Regrant 01 (ptr=2 wraps around), non-owner request change ignored.
        add(0, 4'b0010, 0, 2'b01, 1, 0);
        add(0, 4'b1011, 0, 2'b01, 1, 0);
        // Reset mid-grant: valid drops, code clears, ptr back to 0.
        add(1, 4'b0010, 0, 2'b00, 0, 0);
        add(0, 4'b1111, 0, 2'b00, 1, 0);
        add(0, 4'b1111, 1, 2'b00, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; req = vecs[i].req; rel = vecs[i].rel;
            step();
            chk($sformatf("vec%0d", i), vecs[i].code, vecs[i].valid, vecs[i].tmo);
        end

        // ---- Hold timeout: valid exactly HOLD_MAX cycles, then 1-cycle pulse
        rst = 1'b1; req = 4'b0000; rel = 1'b0;
        step();
        rst = 1'b0; req = 4'b0001;
        for (int k = 0; k < HOLD_MAX; k++) begin
            step();
            chk($sformatf("hold%0d", k), 2'b00, 1'b1, 1'b0);
        end
        step();
        chk("tmo_pulse", 2'b00, 1'b0, 1'b1);
        step();
        chk("tmo_regrant", 2'b00, 1'b1, 1'b0);

        // ---- Wrap: grant 10 then ptr=3, req 0011 must pick 00
        req = 4'b0000;
        step();
        chk("drop0", 2'b00, 1'b0, 1'b0);
        req = 4'b0100;
        step();
        chk("grant2", 2'b10, 1'b1, 1'b0);
        rel = 1'b1;
        step();
        chk("rel2", 2'b10, 1'b0, 1'b0);
        rel = 1'b0; req = 4'b0011;
        step();
        chk("wrap_to0", 2'b00, 1'b1, 1'b0);
        // Release coinciding with the last hold cycle: no timeout.
        for (int k = 1; k < HOLD_MAX; k++) begin
            step();
        end
        chk("last_hold", 2'b00, 1'b1, 1'b0);
        rel = 1'b1;
        step();
        chk("rel_at_limit", 2'b00, 1'b0, 1'b0);
        rel = 1'b0; req = 4'b0000;
        step();
        chk("no_late_tmo", 2'b00, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
